// File: rtl/id_ex_pipe.sv
// ---------------------------------------------------------------------------
// id_ex_pipe
// ID/EX pipeline register for a 5-stage MIPS-style core, with load-use hazard
// detection, flush squashing and a saturating bubble counter.
//
// Ports
//   clk, reset           : single clock, synchronous active-high reset
//   id_* (10 ctrl bits)  : decode-stage control from the control unit
//   id_rdata1/2, id_imm,
//   id_pc4               : operands, sign-extended immediate, PC+4 (DATA_W)
//   id_rs, id_rt, id_rd  : instruction register fields (5 bits)
//   flush                : squash the instruction entering EX
//   ex_*                 : registered EX-stage copies of the id_* inputs
//   ex_valid             : EX slot holds a real instruction
//   stall                : combinational load-use hazard to upstream stages
//   bubble_cnt           : saturating count of bubbles inserted since reset
//
// Slot FSM
//   state    | meaning
//   S_VALID  | EX holds a real instruction
//   S_BUBBLE | EX holds a bubble (all control bits zero)
// ---------------------------------------------------------------------------
module id_ex_pipe #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              id_RegDest,
    input  logic              id_Branch,
    input  logic              id_MemRead,
    input  logic              id_MemToReg,
    input  logic              id_ALUOp1,
    input  logic              id_ALUOp2,
    input  logic              id_MemWrite,
    input  logic              id_ALUSrc,
    input  logic              id_RegWrite,
    input  logic              id_Jump,

    input  logic [DATA_W-1:0] id_rdata1,
    input  logic [DATA_W-1:0] id_rdata2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [DATA_W-1:0] id_pc4,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [4:0]        id_rd,

    input  logic              flush,

    output logic              ex_RegDest,
    output logic              ex_Branch,
    output logic              ex_MemRead,
    output logic              ex_MemToReg,
    output logic              ex_ALUOp1,
    output logic              ex_ALUOp2,
    output logic              ex_MemWrite,
    output logic              ex_ALUSrc,
    output logic              ex_RegWrite,
    output logic              ex_Jump,

    output logic [DATA_W-1:0] ex_rdata1,
    output logic [DATA_W-1:0] ex_rdata2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [DATA_W-1:0] ex_pc4,
    output logic [4:0]        ex_rs,
    output logic [4:0]        ex_rt,
    output logic [4:0]        ex_rd,

    output logic              ex_valid,
    output logic              stall,
    output logic [15:0]       bubble_cnt
);

    typedef enum logic {
        S_BUBBLE = 1'b0,
        S_VALID  = 1'b1
    } slot_state_t;

    slot_state_t r_state;
    slot_state_t w_next_state;

    logic [9:0]  r_ctrl;
    logic [9:0]  w_id_ctrl;
    logic [15:0] r_bubble_cnt;
    logic        w_hazard;
    logic        w_bubble;

    assign w_id_ctrl = {id_RegDest, id_Branch, id_MemRead, id_MemToReg, id_ALUOp1,
                        id_ALUOp2, id_MemWrite, id_ALUSrc, id_RegWrite, id_Jump};

    // Hazard uses only registered EX state and the current ID fields, so flush
    // never reaches stall combinationally. Register 0 is hardwired and never
    // a true dependency.
    assign w_hazard = (r_state == S_VALID) && r_ctrl[7] && (ex_rt != 5'd0) &&
                      ((ex_rt == id_rs) || (ex_rt == id_rt));

    // A flush that coincides with a stall still yields a single bubble.
    assign w_bubble = flush | w_hazard;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_BUBBLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_VALID:  w_next_state = w_bubble ? S_BUBBLE : S_VALID;
            S_BUBBLE: w_next_state = w_bubble ? S_BUBBLE : S_VALID;
            default:  w_next_state = S_BUBBLE;
        endcase
    end

    // Output logic
    always_comb begin
        ex_valid = (r_state == S_VALID);
        stall    = w_hazard;
    end

    // Control bits: zeroed on a bubble so the squashed slot has no side effects.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ctrl <= '0;
        end else if (w_bubble) begin
            r_ctrl <= '0;
        end else begin
            r_ctrl <= w_id_ctrl;
        end
    end

    assign {ex_RegDest, ex_Branch, ex_MemRead, ex_MemToReg, ex_ALUOp1,
            ex_ALUOp2, ex_MemWrite, ex_ALUSrc, ex_RegWrite, ex_Jump} = r_ctrl;

    // Data and field registers load unconditionally outside reset; their
    // contents in a bubble are ignored downstream but stay deterministic.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_rdata1 <= '0;
            ex_rdata2 <= '0;
            ex_imm    <= '0;
            ex_pc4    <= '0;
            ex_rs     <= '0;
            ex_rt     <= '0;
            ex_rd     <= '0;
        end else begin
            ex_rdata1 <= id_rdata1;
            ex_rdata2 <= id_rdata2;
            ex_imm    <= id_imm;
            ex_pc4    <= id_pc4;
            ex_rs     <= id_rs;
            ex_rt     <= id_rt;
            ex_rd     <= id_rd;
        end
    end

    // Saturating bubble counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bubble_cnt <= '0;
        end else if (w_bubble && (r_bubble_cnt != 16'hFFFF)) begin
            r_bubble_cnt <= r_bubble_cnt + 16'd1;
        end
    end

    assign bubble_cnt = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_pipe.sv
module tb_id_ex_pipe;

    localparam int DATA_W = 32;

    // control vector order: RegDest,Branch,MemRead,MemToReg,ALUOp1,ALUOp2,
    //                       MemWrite,ALUSrc,RegWrite,Jump
    localparam logic [9:0] C_RFMT = 10'b1000100010;
    localparam logic [9:0] C_LW   = 10'b0011000110;
    localparam logic [9:0] C_NONE = 10'b0000000000;

    logic              clk = 1'b0;
    logic              reset;
    logic              flush;
    logic [9:0]        id_ctrl;
    logic [DATA_W-1:0] id_rdata1, id_rdata2, id_imm, id_pc4;
    logic [4:0]        id_rs, id_rt, id_rd;

    logic              ex_RegDest, ex_Branch, ex_MemRead, ex_MemToReg, ex_ALUOp1;
    logic              ex_ALUOp2, ex_MemWrite, ex_ALUSrc, ex_RegWrite, ex_Jump;
    logic [DATA_W-1:0] ex_rdata1, ex_rdata2, ex_imm, ex_pc4;
    logic [4:0]        ex_rs, ex_rt, ex_rd;
    logic              ex_valid, stall;
    logic [15:0]       bubble_cnt;
    logic [9:0]        ex_ctrl;

    assign ex_ctrl = {ex_RegDest, ex_Branch, ex_MemRead, ex_MemToReg, ex_ALUOp1,
                      ex_ALUOp2, ex_MemWrite, ex_ALUSrc, ex_RegWrite, ex_Jump};

    always #5 clk = ~clk;

    id_ex_pipe #(.DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset),
        .id_RegDest(id_ctrl[9]), .id_Branch(id_ctrl[8]), .id_MemRead(id_ctrl[7]),
        .id_MemToReg(id_ctrl[6]), .id_ALUOp1(id_ctrl[5]), .id_ALUOp2(id_ctrl[4]),
        .id_MemWrite(id_ctrl[3]), .id_ALUSrc(id_ctrl[2]), .id_RegWrite(id_ctrl[1]),
        .id_Jump(id_ctrl[0]),
        .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm), .id_pc4(id_pc4),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .flush(flush),
        .ex_RegDest(ex_RegDest), .ex_Branch(ex_Branch), .ex_MemRead(ex_MemRead),
        .ex_MemToReg(ex_MemToReg), .ex_ALUOp1(ex_ALUOp1), .ex_ALUOp2(ex_ALUOp2),
        .ex_MemWrite(ex_MemWrite), .ex_ALUSrc(ex_ALUSrc), .ex_RegWrite(ex_RegWrite),
        .ex_Jump(ex_Jump),
        .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2), .ex_imm(ex_imm), .ex_pc4(ex_pc4),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_valid(ex_valid), .stall(stall), .bubble_cnt(bubble_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit quiet   = 1'b0;

    // Reference model: what the EX slot should hold.
    bit                m_valid;
    logic [9:0]        m_ctrl;
    logic [DATA_W-1:0] m_rdata1, m_rdata2, m_imm, m_pc4;
    logic [4:0]        m_rs, m_rt, m_rd;
    int                m_cnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit model_stall();
        // An instruction in EX that is a load whose destination is a nonzero
        // register read by the instruction in ID forces a stall.
        return m_valid && m_ctrl[7] && (m_rt != 0) && (m_rt == id_rs || m_rt == id_rt);
    endfunction

    task automatic set_id(input logic [9:0] c, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd);
        id_ctrl   = c;
        id_rs     = rs;
        id_rt     = rt;
        id_rd     = rd;
        id_rdata1 = $urandom;
        id_rdata2 = $urandom;
        id_imm    = $urandom;
        id_pc4    = $urandom;
    endtask

    // Inputs are driven after a negedge; one call advances one clock edge.
    task automatic tick();
        bit exp_stall;
        #1;
        exp_stall = model_stall();
        if (!quiet) chk("stall", stall, exp_stall);
        @(posedge clk);
        if (reset) begin
            m_valid = 0; m_ctrl = '0; m_cnt = 0;
            m_rdata1 = '0; m_rdata2 = '0; m_imm = '0; m_pc4 = '0;
            m_rs = '0; m_rt = '0; m_rd = '0;
        end else begin
            if (flush || exp_stall) begin
                m_valid = 0;
                m_ctrl  = '0;
                if (m_cnt < 65535) m_cnt++;
            end else begin
                m_valid = 1;
                m_ctrl  = id_ctrl;
            end
            m_rdata1 = id_rdata1; m_rdata2 = id_rdata2; m_imm = id_imm; m_pc4 = id_pc4;
            m_rs = id_rs; m_rt = id_rt; m_rd = id_rd;
        end
        #1;
        if (!quiet) begin
            chk("ex_valid", ex_valid, m_valid);
            chk("ex_ctrl", ex_ctrl, m_ctrl);
            chk("ex_rdata1", ex_rdata1, m_rdata1);
            chk("ex_rdata2", ex_rdata2, m_rdata2);
            chk("ex_imm", ex_imm, m_imm);
            chk("ex_pc4", ex_pc4, m_pc4);
            chk("ex_fields", {ex_rs, ex_rt, ex_rd}, {m_rs, m_rt, m_rd});
            chk("bubble_cnt", bubble_cnt, m_cnt[15:0]);
        end
        @(negedge clk);
    endtask

    initial begin
        int cnt0;
        reset = 1'b1; flush = 1'b0;
        set_id(C_NONE, 5'd0, 5'd0, 5'd0);
        @(negedge clk);
        tick();
        reset = 1'b0;
        #1;
        chk("rst_stall", stall, 0);
        chk("rst_valid", ex_valid, 0);
        chk("rst_cnt", bubble_cnt, 0);

        // R-format
        set_id(C_RFMT, 5'd1, 5'd2, 5'd3);
        id_rdata1 = 32'h5; id_rdata2 = 32'h7;
        tick();
        chk("rfmt_rdata1", ex_rdata1, 32'h5);
        chk("rfmt_rdata2", ex_rdata2, 32'h7);
        chk("rfmt_rd", ex_rd, 5'd3);
        chk("rfmt_ctrl", ex_ctrl, C_RFMT);
        chk("rfmt_valid", ex_valid, 1);

        // Load-use stall
        set_id(C_LW, 5'd4, 5'd8, 5'd0);
        tick();
        cnt0 = m_cnt;
        set_id(C_RFMT, 5'd8, 5'd9, 5'd10);
        #1 chk("lu_stall", stall, 1);
        tick();
        chk("lu_bubble_valid", ex_valid, 0);
        chk("lu_bubble_ctrl", ex_ctrl, C_NONE);
        chk("lu_bubble_cnt", bubble_cnt, cnt0 + 1);
        #1 chk("lu_stall_released", stall, 0);
        tick();
        chk("lu_dep_loaded", {ex_valid, ex_ctrl, ex_rs}, {1'b1, C_RFMT, 5'd8});

        // Load into $zero never stalls
        set_id(C_LW, 5'd4, 5'd0, 5'd0);
        tick();
        cnt0 = m_cnt;
        set_id(C_RFMT, 5'd0, 5'd0, 5'd1);
        #1 chk("r0_stall", stall, 0);
        tick();
        chk("r0_no_bubble", {ex_valid, bubble_cnt}, {1'b1, cnt0[15:0]});

        // Flush coinciding with stall: one bubble
        set_id(C_LW, 5'd4, 5'd8, 5'd0);
        tick();
        cnt0 = m_cnt;
        set_id(C_RFMT, 5'd8, 5'd8, 5'd2);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fs_cnt", bubble_cnt, cnt0 + 1);
        chk("fs_valid", ex_valid, 0);

        // Reset while a load sits in EX
        set_id(C_LW, 5'd4, 5'd8, 5'd0);
        tick();
        set_id(C_RFMT, 5'd8, 5'd8, 5'd2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("mid_rst_all", {ex_valid, ex_ctrl, ex_rdata1, ex_rt, bubble_cnt, stall}, '0);
        set_id(C_RFMT, 5'd1, 5'd2, 5'd3);
        tick();
        chk("post_rst_load", ex_valid, 1);

        // Randomized traffic with frequent register aliasing
        for (int i = 0; i < 400; i++) begin
            logic [9:0] c;
            c = 10'($urandom);
            if ($urandom_range(0, 2) == 0) c[7] = 1'b1;
            set_id(c, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom));
            flush = ($urandom_range(0, 7) == 0);
            reset = ($urandom_range(0, 49) == 0);
            tick();
        end
        reset = 1'b0; flush = 1'b0;

        // Saturation
        reset = 1'b1;
        tick();
        reset = 1'b0;
        flush = 1'b1;
        quiet = 1'b1;
        for (int i = 0; i < 65535; i++) tick();
        quiet = 1'b0;
        chk("sat_full", bubble_cnt, 16'hFFFF);
        tick();
        chk("sat_hold", bubble_cnt, 16'hFFFF);
        flush = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
